// File: rtl/log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_pkg
// Description : Log-number field widths, unpacked operand struct and 2^frac ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package log_pkg;

    localparam int M                  = 5;
    localparam int F                  = 4;
    localparam int LOG_TO_LINEAR_BITS = 8;
    localparam int C_LOG_W            = M + F;

    typedef struct packed {
        logic                      sign;
        logic                      zero;
        logic                      inf;
        logic signed [C_LOG_W-1:0] log;
    } log_num_t;

    // round(2^(f/16) * 2^8); the table is tied to F=4 and LOG_TO_LINEAR_BITS=8
    function automatic logic [LOG_TO_LINEAR_BITS:0] exp2_frac(input logic [F-1:0] f);
        logic [LOG_TO_LINEAR_BITS:0] t;
        case (f)
            4'd0:    t = 9'd256;
            4'd1:    t = 9'd267;
            4'd2:    t = 9'd279;
            4'd3:    t = 9'd292;
            4'd4:    t = 9'd304;
            4'd5:    t = 9'd318;
            4'd6:    t = 9'd332;
            4'd7:    t = 9'd347;
            4'd8:    t = 9'd362;
            4'd9:    t = 9'd378;
            4'd10:   t = 9'd395;
            4'd11:   t = 9'd412;
            4'd12:   t = 9'd431;
            4'd13:   t = 9'd450;
            4'd14:   t = 9'd470;
            default: t = 9'd490;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/log_mac_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : log_mac_unit_if
// Description : Operand / accumulator bundle of the log-domain MAC cell.
// Revision    : 1.0 - initial release
// ============================================================================
interface log_mac_unit_if #(
    parameter int ACC_W = 32
);
    import log_pkg::*;

    logic               in_valid;
    logic               acc_clear;
    logic               a_sign;
    logic               a_zero;
    logic               a_inf;
    logic [C_LOG_W-1:0] a_log;
    logic               b_sign;
    logic               b_zero;
    logic               b_inf;
    logic [C_LOG_W-1:0] b_log;
    logic [ACC_W-1:0]   acc_out;
    logic               acc_valid;
    logic               acc_ovf;

    modport master (
        output in_valid, acc_clear,
        output a_sign, a_zero, a_inf, a_log,
        output b_sign, b_zero, b_inf, b_log,
        input  acc_out, acc_valid, acc_ovf
    );

    modport slave (
        input  in_valid, acc_clear,
        input  a_sign, a_zero, a_inf, a_log,
        input  b_sign, b_zero, b_inf, b_log,
        output acc_out, acc_valid, acc_ovf
    );

endinterface
`default_nettype wire

// File: rtl/log_to_linear.sv
`default_nettype none
// ============================================================================
// Module      : log_to_linear
// Description : Product log to linear fixed-point magnitude (ROM + shift).
// Revision    : 1.0 - initial release
// ============================================================================
module log_to_linear
    import log_pkg::*;
#(
    parameter int PW       = 10,
    parameter int ACC_W    = 32,
    parameter int ACC_FRAC = 16
) (
    input  wire logic [PW-1:0]    i_p_log,
    output      logic [ACC_W-1:0] o_mag,
    output      logic             o_mag_ovf
);

    localparam int C_TW = LOG_TO_LINEAR_BITS + 1;

    logic [C_TW-1:0]    w_t;
    logic [ACC_W-1:0]   w_t_ext;
    logic signed [31:0] w_shift;

    assign w_t     = exp2_frac(i_p_log[F-1:0]);
    assign w_t_ext = {{(ACC_W-C_TW){1'b0}}, w_t};
    // Integer part is the arithmetic floor of the log; rebias it by the fraction widths.
    assign w_shift = $signed({{(32-PW+F){i_p_log[PW-1]}}, i_p_log[PW-1:F]})
                   + (ACC_FRAC - LOG_TO_LINEAR_BITS);

    always_comb begin
        o_mag = '0;
        if (w_shift >= 0) begin
            o_mag = w_t_ext << w_shift;
        end else begin
            o_mag = w_t_ext >> (-w_shift);
        end
    end

    // The table MSB is always set, so overflow is purely a function of the shift.
    assign o_mag_ovf = (w_shift > (ACC_W - C_TW));

endmodule
`default_nettype wire

// File: rtl/log_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : log_mac_unit
// Description : Two-stage log-domain multiply into a Kulisch accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module log_mac_unit
    import log_pkg::*;
#(
    parameter int M_OUT              = M + 1,
    parameter int SATURATE_MAX       = 1,
    parameter int ACC_NON_FRAC       = 16,
    parameter int ACC_FRAC           = 16,
    parameter int OVERFLOW_DETECTION = 0
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    log_mac_unit_if.slave    bus
);

    localparam int C_PW = M_OUT + F;
    localparam int C_SW = C_LOG_W + 1;
    localparam int C_WW = (C_SW > C_PW) ? C_SW : C_PW;
    localparam int C_AW = ACC_NON_FRAC + ACC_FRAC;
    localparam logic signed [C_WW-1:0] C_P_MAX = C_WW'((1 << (C_PW - 1)) - 1);
    localparam logic signed [C_WW-1:0] C_P_MIN = C_WW'(-(1 << (C_PW - 1)));

    log_num_t                w_a;
    log_num_t                w_b;
    logic signed [C_WW-1:0]  w_sum;
    logic [C_PW-1:0]         w_p_log;

    logic                    r_p_valid;
    logic                    r_p_sign;
    logic                    r_p_zero;
    logic                    r_p_inf;
    logic [C_PW-1:0]         r_p_log;

    logic [C_AW-1:0]         r_acc;
    logic                    r_acc_valid;
    logic                    r_acc_ovf;

    logic [C_AW-1:0]         w_mag;
    logic                    w_mag_ovf;
    logic [C_AW-1:0]         w_addend;
    logic [C_AW+1:0]         w_acc_ext;
    logic [C_AW+1:0]         w_add_ext;
    logic [C_AW+1:0]         w_acc_sum;
    logic                    w_add_ovf;
    logic                    w_ovf_evt;

    assign w_a = '{sign: bus.a_sign, zero: bus.a_zero, inf: bus.a_inf, log: bus.a_log};
    assign w_b = '{sign: bus.b_sign, zero: bus.b_zero, inf: bus.b_inf, log: bus.b_log};

    assign w_sum = $signed({{(C_WW-C_LOG_W){w_a.log[C_LOG_W-1]}}, w_a.log})
                 + $signed({{(C_WW-C_LOG_W){w_b.log[C_LOG_W-1]}}, w_b.log});

    // Out-of-range sums either clamp or keep their low bits (wrap).
    always_comb begin
        w_p_log = w_sum[C_PW-1:0];
        if (SATURATE_MAX != 0) begin
            if (w_sum > C_P_MAX) begin
                w_p_log = C_P_MAX[C_PW-1:0];
            end else if (w_sum < C_P_MIN) begin
                w_p_log = C_P_MIN[C_PW-1:0];
            end
        end
    end

    log_to_linear #(
        .PW       (C_PW),
        .ACC_W    (C_AW),
        .ACC_FRAC (ACC_FRAC)
    ) u_log_to_linear (
        .i_p_log   (r_p_log),
        .o_mag     (w_mag),
        .o_mag_ovf (w_mag_ovf)
    );

    // Two guard bits hold any acc +/- unsigned magnitude exactly.
    assign w_addend  = (r_p_zero || r_p_inf) ? '0 : w_mag;
    assign w_acc_ext = {{2{r_acc[C_AW-1]}}, r_acc};
    assign w_add_ext = {2'b00, w_addend};
    assign w_acc_sum = r_p_sign ? (w_acc_ext - w_add_ext) : (w_acc_ext + w_add_ext);
    assign w_add_ovf = (w_acc_sum[C_AW+1:C_AW-1] != 3'b000) &&
                       (w_acc_sum[C_AW+1:C_AW-1] != 3'b111);
    assign w_ovf_evt = (OVERFLOW_DETECTION != 0) &&
                       (r_p_inf || (!r_p_zero && (w_mag_ovf || w_add_ovf)));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_p_valid   <= 1'b0;
            r_p_sign    <= 1'b0;
            r_p_zero    <= 1'b0;
            r_p_inf     <= 1'b0;
            r_p_log     <= '0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_acc_ovf   <= 1'b0;
        end else begin
            r_p_valid <= bus.in_valid;
            r_p_sign  <= w_a.sign ^ w_b.sign;
            r_p_zero  <= w_a.zero | w_b.zero;
            r_p_inf   <= (w_a.inf | w_b.inf) & ~(w_a.zero | w_b.zero);
            r_p_log   <= w_p_log;
            if (bus.acc_clear) begin
                r_acc       <= '0;
                r_acc_valid <= 1'b0;
                r_acc_ovf   <= 1'b0;
            end else if (r_p_valid) begin
                r_acc       <= w_acc_sum[C_AW-1:0];
                r_acc_valid <= 1'b1;
                r_acc_ovf   <= r_acc_ovf | w_ovf_evt;
            end else begin
                r_acc_valid <= 1'b0;
            end
        end
    end

    assign bus.acc_out   = r_acc;
    assign bus.acc_valid = r_acc_valid;
    assign bus.acc_ovf   = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_log_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_mac_unit
// Description : Directed and random checks of log_mac_unit against a real-math model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_mac_unit;
    import log_pkg::*;

    localparam int     AW      = 32;
    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;
    localparam longint MAG_LIM = 64'sd4294967296;

    logic clock;
    logic resetn;

    log_mac_unit_if #(.ACC_W(AW)) bus ();

    log_mac_unit #(
        .SATURATE_MAX       (1),
        .ACC_NON_FRAC       (16),
        .ACC_FRAC           (16),
        .OVERFLOW_DETECTION (1)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what was driven this cycle, the product in flight, the accumulator.
    bit          cur_v, cur_clr, cur_as, cur_az, cur_ai, cur_bs, cur_bz, cur_bi;
    int          cur_al, cur_bl;
    bit          p_v, p_sign, p_zero, p_inf;
    int          p_log;
    logic [31:0] m_acc;
    bit          m_valid, m_ovf;

    task automatic drive(input bit v, input bit clr,
                         input bit as, input bit az, input bit ai, input int al,
                         input bit bs, input bit bz, input bit bi, input int bl);
        bus.in_valid  = v;   bus.acc_clear = clr;
        bus.a_sign    = as;  bus.a_zero = az; bus.a_inf = ai; bus.a_log = C_LOG_W'(al);
        bus.b_sign    = bs;  bus.b_zero = bz; bus.b_inf = bi; bus.b_log = C_LOG_W'(bl);
        cur_v = v;  cur_clr = clr;
        cur_as = as; cur_az = az; cur_ai = ai; cur_al = al;
        cur_bs = bs; cur_bz = bz; cur_bi = bi; cur_bl = bl;
    endtask

    task automatic idle(input bit clr);
        drive(1'b0, clr, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic model_reset();
        m_acc = '0; m_valid = 1'b0; m_ovf = 1'b0;
        p_v = 1'b0; p_sign = 1'b0; p_zero = 1'b0; p_inf = 1'b0; p_log = 0;
    endtask

    // Value of the product = (+/-) 2^(p_log/16), placed on a 2^-16 grid.
    task automatic model_edge();
        if (cur_clr) begin
            m_acc = '0; m_ovf = 1'b0; m_valid = 1'b0;
        end else if (p_v) begin
            m_valid = 1'b1;
            if (p_inf) begin
                m_ovf = 1'b1;
            end else if (!p_zero) begin
                int     e, f, s, t;
                longint mag, exact;
                f = p_log & 15;
                e = p_log >>> 4;
                t = $rtoi(256.0 * (2.0 ** (real'(f) / 16.0)) + 0.5);
                s = e + 16 - 8;
                mag = (s >= 0) ? (longint'(t) << s) : (longint'(t) >> (-s));
                exact = longint'($signed(m_acc)) + (p_sign ? -mag : mag);
                if (mag >= MAG_LIM || exact > ACC_MAX || exact < ACC_MIN) m_ovf = 1'b1;
                m_acc = exact[31:0];
            end
        end else begin
            m_valid = 1'b0;
        end
        p_v    = cur_v;
        p_sign = cur_as ^ cur_bs;
        p_zero = cur_az | cur_bz;
        p_inf  = (cur_ai | cur_bi) & !p_zero;
        p_log  = cur_al + cur_bl;
        if (p_log > 511)  p_log = 511;
        if (p_log < -512) p_log = -512;
    endtask

    task automatic check_bus(input string tag);
        n_cmp++;
        assert (bus.acc_out === m_acc) else begin
            n_err++; $error("FAIL %s acc_out got %h exp %h", tag, bus.acc_out, m_acc);
        end
        n_cmp++;
        assert (bus.acc_valid === m_valid) else begin
            n_err++; $error("FAIL %s acc_valid got %b exp %b", tag, bus.acc_valid, m_valid);
        end
        n_cmp++;
        assert (bus.acc_ovf === m_ovf) else begin
            n_err++; $error("FAIL %s acc_ovf got %b exp %b", tag, bus.acc_ovf, m_ovf);
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++; $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_bus(tag);
    endtask

    function automatic int rnd_log();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 511)) - 256;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        resetn = 1'b0;
        idle(1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_acc", bus.acc_out, 32'h0);
        check_eq("rst_valid", {31'd0, bus.acc_valid}, 32'h0);
        check_eq("rst_ovf", {31'd0, bus.acc_ovf}, 32'h0);
        resetn = 1'b1;

        // 1.0 * 1.0
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("one_s1");
        idle(0);                             tick("one_s2");
        check_eq("one_val", bus.acc_out, 32'h0001_0000);

        // 2.0 * 4.0 then the negated product
        idle(1);                                tick("clr0");
        drive(1, 0, 0, 0, 0, 16, 0, 0, 0, 32);  tick("eight_s1");
        idle(0);                                tick("eight_s2");
        check_eq("eight_val", bus.acc_out, 32'h0008_0000);
        drive(1, 0, 1, 0, 0, 16, 0, 0, 0, 32);  tick("neg_s1");
        idle(0);                                tick("neg_s2");
        check_eq("neg_val", bus.acc_out, 32'h0);

        // sqrt(2) and a zero operand
        drive(1, 0, 0, 0, 0, 8, 0, 0, 0, 0);    tick("sqrt_s1");
        idle(0);                                tick("sqrt_s2");
        check_eq("sqrt_val", bus.acc_out, 32'h0001_6A00);
        drive(1, 0, 0, 1, 0, 37, 0, 0, 0, -5);  tick("zero_s1");
        idle(0);                                tick("zero_s2");
        check_eq("zero_val", bus.acc_out, 32'h0001_6A00);

        // Largest logs overflow the accumulator; flag is sticky until clear
        drive(1, 0, 0, 0, 0, 255, 0, 0, 0, 255); tick("ovf_s1");
        idle(0);                                 tick("ovf_s2");
        check_eq("ovf_set", {31'd0, bus.acc_ovf}, 32'h1);
        repeat (3) begin idle(0); tick("ovf_hold"); end
        check_eq("ovf_sticky", {31'd0, bus.acc_ovf}, 32'h1);
        idle(1); tick("ovf_clr");
        check_eq("ovf_cleared", {31'd0, bus.acc_ovf}, 32'h0);

        // Back-to-back accumulation
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick("b2b");
            if (i > 0) check_eq("b2b_step", bus.acc_out, 32'(i) << 16);
        end
        idle(0); tick("b2b_end");
        check_eq("b2b_four", bus.acc_out, 32'h0004_0000);

        // Clear mid-stream: the add landing with the clear is lost, later ones resume
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("mid1");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("mid2");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick("mid3");
        check_eq("mid_clr", bus.acc_out, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("mid4");
        idle(0); tick("mid5");
        idle(0); tick("mid6");
        check_eq("mid_resume", bus.acc_out, 32'h0002_0000);

        // Random operand streams with occasional clears, zeros and infinities
        for (int i = 0; i < 300; i++) begin
            bit v, clr;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            drive(v, clr,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0), rnd_log(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0), rnd_log());
            tick("rand");
        end

        // Asynchronous reset in the middle of accumulation
        idle(1); tick("pre_rst_clr");
        repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("pre_rst"); end
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_eq("arst_acc", bus.acc_out, 32'h0);
        check_eq("arst_valid", {31'd0, bus.acc_valid}, 32'h0);
        idle(0);
        @(posedge clock);
        #1;
        check_bus("in_rst");
        #2 resetn = 1'b1;
        idle(0); tick("post_rst1");
        idle(0); tick("post_rst2");
        check_eq("post_rst_acc", bus.acc_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
